shader_result_collector: RTL and testbench

//  Multi-channel shader result collector. Merges NUM_CH shader-lane result streams
//  (scalar or vector) into one ordered output stream, via a round-robin arbiter and a

---
 rtl/shader_result_pkg.sv | 16 +
 rtl/shader_result_rr_arb.sv | 45 ++++
 rtl/shader_result_collector.sv | 128 ++++++++++++
 tb/tb_shader_result_collector.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/shader_result_pkg.sv
// Shared defaults and entry layout for the shader result collector.
package shader_result_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_LANES  = 4;
  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_DEPTH  = 4;

  // Stored entry bit width; field order MSB..LSB is {ch, is_vec, mask, s, v}.
  function automatic int unsigned entry_w(input int unsigned width,
                                          input int unsigned lanes,
                                          input int unsigned num_ch);
    return $clog2(num_ch) + 1 + lanes + width + width * lanes;
  endfunction

endpackage

// File: rtl/shader_result_rr_arb.sv
// Round-robin arbiter: searches from the channel after the last accepted grant.
module shader_result_rr_arb
  import shader_result_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         req,
  input  logic                      advance,
  output logic [NUM_CH-1:0]         gnt,
  output logic [$clog2(NUM_CH)-1:0] gnt_idx
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic [CH_W-1:0] last_grant;
  logic            found;
  int unsigned     idx;

  // Reset to the last channel so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= CH_W'(NUM_CH - 1);
    end else if (advance) begin
      last_grant <= gnt_idx;
    end
  end

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx = (32'(last_grant) + k) % NUM_CH;
      if (!found && req[CH_W'(idx)]) begin
        found              = 1'b1;
        gnt[CH_W'(idx)]    = 1'b1;
        gnt_idx            = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/shader_result_collector.sv
// Merges per-channel scalar/vector shader results into one ordered stream
// through a round-robin arbiter and a small normalising FIFO.
module shader_result_collector
  import shader_result_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CH-1:0]                 in_valid,
  output logic [NUM_CH-1:0]                 in_ready,
  input  logic [NUM_CH-1:0]                 in_is_vec,
  input  logic [NUM_CH*LANES-1:0]           in_mask,
  input  logic [NUM_CH*WIDTH-1:0]           in_result_s,
  input  logic [NUM_CH*WIDTH*LANES-1:0]     in_result_v,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(NUM_CH)-1:0]         out_ch,
  output logic                              out_is_vec,
  output logic [LANES-1:0]                  out_mask,
  output logic [WIDTH-1:0]                  out_result_s,
  output logic [WIDTH*LANES-1:0]            out_result_v,
  output logic [$clog2(DEPTH+1)-1:0]        count
);

  localparam int unsigned VEC_W   = WIDTH * LANES;
  localparam int unsigned CH_W    = $clog2(NUM_CH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned ENTRY_W = entry_w(WIDTH, LANES, NUM_CH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [NUM_CH-1:0]  gnt;
  logic [CH_W-1:0]    gnt_idx;
  logic               can_push;
  logic               push;
  logic               pop;
  logic               sel_vec;
  logic [LANES-1:0]   sel_mask;
  logic [WIDTH-1:0]   sel_s;
  logic [VEC_W-1:0]   sel_v;
  logic [LANES-1:0]   wr_mask;
  logic [WIDTH-1:0]   wr_s;
  logic [VEC_W-1:0]   wr_v;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready & ~rst;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign can_push  = ~rst & ((count < CNT_W'(DEPTH)) | (out_valid & out_ready));
  assign in_ready  = can_push ? gnt : '0;
  assign push      = |(in_valid & in_ready);

  shader_result_rr_arb #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid),
    .advance (push),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Mux the granted channel's payload.
  always_comb begin
    sel_vec  = 1'b0;
    sel_mask = '0;
    sel_s    = '0;
    sel_v    = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (gnt[c]) begin
        sel_vec  = in_is_vec[c];
        sel_mask = in_mask[c*LANES +: LANES];
        sel_s    = in_result_s[c*WIDTH +: WIDTH];
        sel_v    = in_result_v[c*VEC_W +: VEC_W];
      end
    end
  end

  // Normalise: scalar drops mask/vector, vector drops scalar and masked-off lanes.
  always_comb begin
    wr_mask = '0;
    wr_s    = '0;
    wr_v    = '0;
    if (sel_vec) begin
      wr_mask = sel_mask;
      for (int l = 0; l < int'(LANES); l++) begin
        if (sel_mask[l]) begin
          wr_v[l*WIDTH +: WIDTH] = sel_v[l*WIDTH +: WIDTH];
        end
      end
    end else begin
      wr_s = sel_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= {gnt_idx, sel_vec, wr_mask, wr_s, wr_v};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign {out_ch, out_is_vec, out_mask, out_result_s, out_result_v} = mem[rd_ptr];

endmodule

// File: tb/tb_shader_result_collector.sv
// Directed self-checking bench for shader_result_collector (default parameters).
module tb_shader_result_collector;

  logic         clk;
  logic         rst;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [3:0]   in_is_vec;
  logic [15:0]  in_mask;
  logic [127:0] in_result_s;
  logic [511:0] in_result_v;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_ch;
  logic         out_is_vec;
  logic [3:0]   out_mask;
  logic [31:0]  out_result_s;
  logic [127:0] out_result_v;
  logic [2:0]   count;

  int checks = 0;
  int errors = 0;

  shader_result_collector dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_is_vec    (in_is_vec),
    .in_mask      (in_mask),
    .in_result_s  (in_result_s),
    .in_result_v  (in_result_v),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ch       (out_ch),
    .out_is_vec   (out_is_vec),
    .out_mask     (out_mask),
    .out_result_s (out_result_s),
    .out_result_v (out_result_v),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; new inputs are applied 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_rdy;
    rst         = 1'b1;
    in_valid    = 4'hF;
    in_is_vec   = 4'h0;
    in_mask     = '0;
    in_result_s = '0;
    in_result_v = '0;
    out_ready   = 1'b0;

    // 1. reset and idle
    step();
    step();
    chk("rst_in_ready", 128'(in_ready), 128'h0);
    in_valid = 4'h0;
    rst = 1'b0;
    #1;
    chk("rst_count", 128'(count), 128'h0);
    chk("rst_out_valid", 128'(out_valid), 128'h0);
    chk("rst_out_ch", 128'(out_ch), 128'h0);
    chk("rst_out_is_vec", 128'(out_is_vec), 128'h0);
    chk("rst_out_mask", 128'(out_mask), 128'h0);
    chk("rst_out_s", 128'(out_result_s), 128'h0);
    chk("rst_out_v", out_result_v, 128'h0);

    // 2. all channels streaming, consumer always ready: grants rotate 0,1,2,3
    for (int c = 0; c < 4; c++) in_result_s[c*32 +: 32] = 32'h100 + 32'(c);
    in_valid  = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_rdy = 4'b0001 << (k % 4);
      chk("rr_in_ready", 128'(in_ready), 128'(exp_rdy));
      step();
      chk("rr_out_ch", 128'(out_ch), 128'(k % 4));
      chk("rr_out_s", 128'(out_result_s), 128'(32'h100 + 32'(k % 4)));
      chk("rr_count", 128'(count), 128'h1);
    end
    in_valid = 4'h0;
    step();
    chk("rr_drain_count", 128'(count), 128'h0);

    // 3. fill with ch2, then full+pop accepts in the same cycle
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      in_result_s[64 +: 32] = 32'h11 + 32'(i);
      #1;
      chk("fill_in_ready", 128'(in_ready), 128'h4);
      step();
    end
    in_result_s[64 +: 32] = 32'h15;
    #1;
    chk("full_count", 128'(count), 128'h4);
    chk("full_in_ready", 128'(in_ready), 128'h0);
    chk("full_head", 128'(out_result_s), 128'h11);
    step();
    chk("full_hold_count", 128'(count), 128'h4);
    out_ready = 1'b1;
    #1;
    chk("full_pop_in_ready", 128'(in_ready), 128'h4);
    step();
    chk("full_pop_count", 128'(count), 128'h4);
    in_valid = 4'h0;
    for (int j = 0; j < 4; j++) begin
      chk("drain_s", 128'(out_result_s), 128'(32'h12 + 32'(j)));
      chk("drain_ch", 128'(out_ch), 128'h2);
      step();
    end
    chk("drain_count", 128'(count), 128'h0);
    chk("drain_out_valid", 128'(out_valid), 128'h0);

    // 4. ch1 vector, mask 0101: lanes 1 and 3 zeroed, scalar dropped
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    in_is_vec = 4'b0010;
    in_mask[4 +: 4] = 4'b0101;
    in_result_s[32 +: 32] = 32'hFFFF_0001;
    in_result_v[128 +: 128] = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    step();
    in_valid = 4'h0;
    chk("vec_count", 128'(count), 128'h1);
    chk("vec_out_ch", 128'(out_ch), 128'h1);
    chk("vec_is_vec", 128'(out_is_vec), 128'h1);
    chk("vec_mask", 128'(out_mask), 128'h5);
    chk("vec_s", 128'(out_result_s), 128'h0);
    chk("vec_v", out_result_v, {32'h0, 32'hCCCC_CCCC, 32'h0, 32'hAAAA_AAAA});
    out_ready = 1'b1;
    step();

    // vector with empty mask keeps is_vec but all lanes zero
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    in_is_vec = 4'b0001;
    in_mask   = '0;
    in_result_v[0 +: 128] = {4{32'h5A5A_5A5A}};
    step();
    in_valid = 4'h0;
    chk("vec0_is_vec", 128'(out_is_vec), 128'h1);
    chk("vec0_mask", 128'(out_mask), 128'h0);
    chk("vec0_v", out_result_v, 128'h0);
    out_ready = 1'b1;
    step();
    chk("vec0_count", 128'(count), 128'h0);

    // 5. ch3 scalar with garbage vector and full mask
    out_ready = 1'b0;
    in_valid  = 4'b1000;
    in_is_vec = 4'b0000;
    in_mask[12 +: 4] = 4'hF;
    in_result_s[96 +: 32] = 32'hDEAD_BEEF;
    in_result_v[384 +: 128] = {4{32'h1234_5678}};
    step();
    chk("sca_out_ch", 128'(out_ch), 128'h3);
    chk("sca_is_vec", 128'(out_is_vec), 128'h0);
    chk("sca_mask", 128'(out_mask), 128'h0);
    chk("sca_s", 128'(out_result_s), 128'hDEAD_BEEF);
    chk("sca_v", out_result_v, 128'h0);

    // 6. queue 3 entries, reset mid-stream, channel 0 wins over 3 afterwards
    in_valid = 4'b0001;
    step();
    in_valid = 4'b0010;
    step();
    in_valid = 4'h0;
    chk("pre_rst_count", 128'(count), 128'h3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_count", 128'(count), 128'h0);
    chk("mid_rst_out_valid", 128'(out_valid), 128'h0);
    in_valid = 4'b1001;
    #1;
    chk("post_rst_in_ready", 128'(in_ready), 128'h1);
    step();
    in_valid = 4'h0;
    chk("post_rst_out_ch", 128'(out_ch), 128'h0);
    chk("post_rst_count", 128'(count), 128'h1);

    // empty + out_ready must not underflow
    out_ready = 1'b1;
    step();
    step();
    chk("underflow_count", 128'(count), 128'h0);
    chk("underflow_out_valid", 128'(out_valid), 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
